fp32_mul_arbiter: RTL and testbench
===================================

// Module: fp32_mul_arbiter
// PURPOSE
//  Shares one pipelined FP32 multiplier (multiply_32 class, fixed latency, no stall) among N_REQ requesters.
//  Round-robin issue, at most one op/cycle. Requester ID tracked through a tag pipeline matched to multiplier latency.
//  Results are returned in issue order through an output FIFO. Credit control guarantees the FIFO never overflows.
//  Sits between NLA compute lanes and the single shared multiplier instance.
// PARAMETERS
//  N_REQ       4   number of requesters (>=2); ID_W = max(1, clog2(N_REQ))
//  MUL_LAT     7   cycles from mul_a/mul_b change to matching mul_result; must equal multiplier pipeline depth
//  FIFO_DEPTH  8   result FIFO entries (power of 2, >=2); also the max outstanding ops
// PORTS
//  clk         in   1           clock; multiplier instance clocked on the same edge
//  rst         in   1           synchronous reset, active-high
//  req_valid   in   N_REQ       per-requester operand valid
//  req_ready   out  N_REQ       per-requester accept (one-hot or zero)
//  req_a       in   N_REQ*32    operand A, requester i at [32*i+:32]
//  req_b       in   N_REQ*32    operand B, same packing
//  mul_a       out  32          registered operand A to multiplier
//  mul_b       out  32          registered operand B to multiplier
//  mul_result  in   32          multiplier output
//  rsp_valid   out  1           result available (FIFO not empty)
//  rsp_ready   in   1           consumer accepts result
//  rsp_id      out  ID_W        requester index of head result
//  rsp_data    out  32          FP32 product of head result
//  busy        out  1           ops in flight or results buffered
// BEHAVIOUR
//  Reset (rst=1 at edge): clears rr pointer to 0, tag pipeline valids, FIFO pointers and outstanding count; mul_a=mul_b=0.
//   Ops in flight at reset are discarded; they never produce rsp_valid.
//  Reset output values: req_ready=0, rsp_valid=0, busy=0; rsp_id/rsp_data=0.
//  req_ready is forced 0 while rst=1.
//  Count: cnt = ops in tag pipeline + FIFO occupancy; range 0..FIFO_DEPTH.
//   cnt += accept, cnt -= pop; simultaneous accept+pop -> cnt unchanged.
//  Issue allowed iff cnt < FIFO_DEPTH (registered cnt; a same-cycle pop is NOT credited).
//  Arbitration: combinational round-robin over req_valid, highest priority at ptr, then ptr+1, ... (mod N_REQ).
//   req_ready[g]=1 only for granted g and only if issue allowed; req_ready may depend on req_valid.
//   Accept = req_valid[g] & req_ready[g]. On accept: ptr <= (g+1) mod N_REQ. No accept -> ptr holds.
//  Operand register: every edge, mul_a/mul_b <= accepted req_a/req_b, else 0 (zero operands on idle cycles).
//  Tag pipeline: MUL_LAT+1 stage shift register of {valid, id}. Stage 0 loaded on accept (valid=0 otherwise).
//   Accept in cycle T -> operands visible T+1 -> mul_result valid in cycle T+1+MUL_LAT, coincident with last tag stage.
//  FIFO write: at end of cycle T+1+MUL_LAT when last tag stage valid; writes {id, mul_result}.
//   Write is never refused (credit guarantees space).
//  FIFO: first-word-fall-through; rsp_valid = !empty; pop on rsp_valid & rsp_ready; rsp_id/rsp_data = head entry.
//   Simultaneous write+pop on an empty FIFO: write lands, pop ignored (rsp_valid was 0).
//   At full: write impossible by credit.
//  Latency: accept in cycle T -> rsp_valid in cycle T+MUL_LAT+2 if FIFO was empty. Throughput 1 op/cycle sustained.
//  Ordering: responses strictly in accept order, across all requesters.
//  Pointer wraps N_REQ-1 -> 0; FIFO pointers wrap modulo FIFO_DEPTH.
//  busy = (cnt != 0).
//  Operand contents are not inspected; zero/special handling is the multiplier's.
// TESTING
//  1 Single op: req0 a=0x40000000 b=0x40400000 accepted cycle T, rsp_ready=1
//    -> rsp_valid first high at T+9, rsp_id=0, rsp_data=0x40C00000; busy low one cycle after pop.
//  2 All req_valid=4'hF held, rsp_ready=1 -> accepts one per cycle in order 0,1,2,3,0,1...; rsp_id stream identical, no gaps.
//  3 rsp_ready=0, req2 always valid -> exactly 8 accepts then req_ready=0, busy=1.
//    Raise rsp_ready -> 8 results in issue order; accepts resume after the first pop.
//  4 Sign/zero: req1 a=0xC0000000 b=0x40400000 -> rsp_data 0xC0C00000.
//    req3 a=0x00000000 b=0x3F800000 -> rsp_data 0x00000000, rsp_id 3.
//  5 Reset mid-flight: 3 ops accepted, rst=1 for 1 cycle two cycles later
//    -> no rsp_valid for 20 cycles, busy=0, next grant goes to req0 first.
//  6 Credit edge: cnt=8, pop and req_valid same cycle -> no accept that cycle, accept next cycle; cnt never exceeds 8.

Source files
------------

// File: rtl/fp32_mul_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined FP32 multiplier among N_REQ lanes.
// Requester IDs ride a tag pipeline alongside the multiplier; results drain in issue order via a FWFT FIFO.
module fp32_mul_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MUL_LAT    = 7,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = ID_W + 32;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_id;
    int unsigned      arb_idx;
    logic             issue_ok;
    logic             accept;
    logic             pop;
    logic             fifo_wr;

    logic [MUL_LAT:0] tag_vld_q;
    logic [ID_W-1:0]  tag_id_q [MUL_LAT+1];

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic [ENT_W-1:0] fifo_head;

    // Round-robin search starting at rr_ptr_q; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            arb_idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!gnt_found && req_valid[arb_idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = arb_idx[ID_W-1:0];
            end
        end
    end

    // Credit uses the registered count only; a same-cycle pop frees space next cycle.
    assign issue_ok = (cnt_q < CNT_W'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = !rst && issue_ok && gnt_found && (gnt_id == ID_W'(i));
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Idle cycles present zero operands to the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= req_a[32*gnt_id +: 32];
            mul_b <= req_b[32*gnt_id +: 32];
        end else begin
            mul_a <= '0;
            mul_b <= '0;
        end
    end

    // Stage MUL_LAT lines up with mul_result for the op accepted MUL_LAT+1 cycles earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[MUL_LAT-1:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int k = 1; k <= MUL_LAT; k++) begin
            tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    assign fifo_wr    = tag_vld_q[MUL_LAT];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {tag_id_q[MUL_LAT], mul_result};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign fifo_head = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign rsp_valid = !fifo_empty;
    assign rsp_id    = rsp_valid ? fifo_head[ENT_W-1:32] : '0;
    assign rsp_data  = rsp_valid ? fifo_head[31:0] : '0;
    assign busy      = (cnt_q != '0);

    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= CNT_W'(FIFO_DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr && fifo_full));
    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Bench for fp32_mul_arbiter: behavioural 7-stage FP32 multiplier stub, accept-side scoreboard
// push and an independent response monitor that pops and compares in order.
module tb_fp32_mul_arbiter;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 7;
    localparam int DEPTH   = 8;

    localparam logic [31:0] F_P2  = 32'h40000000;  //  2.0
    localparam logic [31:0] F_M2  = 32'hC0000000;  // -2.0
    localparam logic [31:0] F_P3  = 32'h40400000;  //  3.0
    localparam logic [31:0] F_1   = 32'h3F800000;  //  1.0
    localparam logic [31:0] F_1P5 = 32'h3FC00000;  //  1.5
    localparam logic [31:0] F_4   = 32'h40800000;  //  4.0
    localparam logic [31:0] F_HLF = 32'h3F000000;  //  0.5

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*32-1:0]  req_a;
    logic [N_REQ*32-1:0]  req_b;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic [31:0]          mul_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_data;
    logic                 busy;

    fp32_mul_arbiter #(
        .N_REQ      (N_REQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Truncating FP32 multiply for normal and zero operands; enough for the directed vectors.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] m;
        logic [9:0]  e;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
        return {s, e[7:0], m[45:23]};
    endfunction

    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[MUL_LAT-1];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [31:0] exp_d [N_REQ];
    logic [33:0] sb_q [$];
    logic [33:0] sb_e;
    int          acc_ids [256];
    int          acc_cnt = 0;
    int          out_cnt = 0;
    int          max_out = 0;

    // Accept side: push expected {id, product} for every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({2'(i), exp_d[i]});
                    if (acc_cnt < 256) acc_ids[acc_cnt] = i;
                    acc_cnt++;
                    out_cnt++;
                    if (out_cnt > max_out) max_out = out_cnt;
                end
            end
        end
    end

    // Response side: compare head of scoreboard on every pop.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, rsp_id}, 32'hFFFFFFFF);
            end else begin
                sb_e = sb_q.pop_front();
                chk("rsp_id", {30'd0, rsp_id}, {30'd0, sb_e[33:32]});
                chk("rsp_data", rsp_data, sb_e[31:0]);
            end
            out_cnt--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        exp_d[i] = e;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
        sb_q.delete();
        out_cnt = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic issue_one(input int i);
        bit ok;
        ok = 1'b0;
        req_valid = 4'(1 << i);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("issue_timeout", 32'(i), 32'hFFFFFFFF);
        tick();
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int start;
        bit seen;
        bit ok;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) exp_d[i] = '0;

        // Reset state; req_ready must stay low while rst is high.
        set_req(0, F_P2, F_P3, 32'h40C00000);
        req_valid = 4'h1;
        tick();
        @(negedge clk);
        chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_mul_a", mul_a, 32'd0);

        // 1: single op latency
        tick();
        rsp_ready = 1'b1;
        req_valid = 4'h1;
        @(negedge clk);
        chk("t1_grant", {28'd0, req_ready}, 32'h1);
        t0 = cyc;
        tick();
        req_valid = '0;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t1_latency", ok ? 32'(cyc - t0) : 32'hFFFFFFFF, 32'd9);
        chk("t1_busy_at_pop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_busy_after_pop", {31'd0, busy}, 32'd0);
        tick();

        // 2: all requesters valid -> strict rotation starting at 0
        reset_dut();
        set_req(0, F_P2, F_P3, 32'h40C00000);
        set_req(1, F_M2, F_P3, 32'hC0C00000);
        set_req(2, F_1P5, F_P2, 32'h40400000);
        set_req(3, F_4, F_HLF, 32'h40000000);
        rsp_ready = 1'b1;
        start = acc_cnt;
        req_valid = 4'hF;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (acc_cnt - start >= 16) break;
        end
        req_valid = '0;
        chk("t2_accepts", 32'(acc_cnt - start), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk("t2_order", 32'(acc_ids[start + k]), 32'(k % 4));
        end
        wait_idle();

        // 3/6: fill credits with consumer stalled, then pop while still requesting
        rsp_ready = 1'b0;
        start = acc_cnt;
        req_valid = 4'b0100;
        repeat (20) tick();
        chk("t3_accepts_full", 32'(acc_cnt - start), 32'd8);
        @(negedge clk);
        chk("t3_ready_full", {28'd0, req_ready}, 32'd0);
        chk("t3_busy_full", {31'd0, busy}, 32'd1);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t6_no_accept_on_pop", {28'd0, req_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("t3_resume_after_pop", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        wait_idle();

        // 6: credit edge with req_valid raised in the same cycle as the first pop
        rsp_ready = 1'b0;
        start = acc_cnt;
        req_valid = 4'b0001;
        repeat (12) tick();
        req_valid = '0;
        repeat (12) tick();
        chk("t6_accepts_full", 32'(acc_cnt - start), 32'd8);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t6_edge_no_accept", {28'd0, req_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("t6_edge_next_accept", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        wait_idle();

        // 4: sign and zero vectors
        set_req(1, F_M2, F_P3, 32'hC0C00000);
        set_req(3, 32'h00000000, F_1, 32'h00000000);
        set_req(0, F_4, F_HLF, 32'h40000000);
        set_req(2, F_1P5, F_P2, 32'h40400000);
        issue_one(1);
        issue_one(3);
        issue_one(0);
        issue_one(2);
        wait_idle();

        // 5: reset with ops in flight
        start = acc_cnt;
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = '0;
        chk("t5_accepts", 32'(acc_cnt - start), 32'd3);
        tick();
        tick();
        rst = 1'b1;
        req_valid = 4'hF;
        sb_q.delete();
        @(negedge clk);
        chk("t5_ready_in_reset", {28'd0, req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        out_cnt = 0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("t5_no_rsp_after_reset", {31'd0, seen}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        chk("t5_first_grant", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        wait_idle();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("max_outstanding_le_8", 32'(max_out <= DEPTH), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
